// File: rtl/rip_const.sv
// Shared constants for the machine-mode CSR file: addresses, cause codes, CSR op encoding.
package rip_const;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam logic [4:0] CAUSE_INSN_MISALIGNED = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL_INSN    = 5'd2;
   localparam logic [4:0] CAUSE_BREAKPOINT      = 5'd3;
   localparam logic [4:0] CAUSE_ECALL_M         = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_BASE        = 5'd16;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/rip_csr_counter.sv
// 64-bit event counter with independently writable 32-bit halves.
module rip_csr_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        lo_we,
   input  logic [31:0] lo_wdata,
   input  logic        hi_we,
   input  logic [31:0] hi_wdata,
   output logic [63:0] count
);

   logic [63:0] count_reg;

   // A write to either half suppresses the increment for that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (lo_we || hi_we) begin
         if (lo_we) count_reg[31:0]  <= lo_wdata;
         if (hi_we) count_reg[63:32] <= hi_wdata;
      end else if (inc) begin
         count_reg <= count_reg + 64'd1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/rip_csr_file.sv
// Machine-mode CSR file: trap entry, MRET, interrupt arbitration, counters and redirect.
module rip_csr_file
   import rip_const::*;
#(
   parameter int              XLEN        = 32,
   parameter int              NUM_IRQ     = 4,
   parameter bit              VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [11:0]        csr_addr,
   input  logic [1:0]         csr_op,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               csr_illegal,
   input  logic               exc_valid,
   input  logic [4:0]         exc_cause,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic [XLEN-1:0]    trap_pc,
   input  logic               mret,
   input  logic               instret,
   input  logic [NUM_IRQ-1:0] irq,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc
);

   logic               mstatus_mie_reg, mstatus_mpie_reg;
   logic [XLEN-1:0]    mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
   logic [NUM_IRQ-1:0] irq_sync_reg;
   logic               redirect_valid_reg;
   logic [XLEN-1:0]    redirect_pc_reg;

   logic [XLEN-1:0]    mip_value, mstatus_value, wval, mtvec_wval, mtvec_rst, mtvec_base;
   logic [63:0]        wval64;
   logic [63:0]        cnt_value [2];
   logic [1:0]         cnt_inc, lo_we, hi_we;
   logic               implemented, read_only, csr_we;
   logic               irq_hit, int_pending;
   logic [4:0]         irq_idx, irq_cause;
   logic [XLEN-1:0]    exc_mcause, int_mcause, int_target;

   always_comb begin
      mip_value = '0;
      mip_value[16 +: NUM_IRQ] = irq_sync_reg;
      mstatus_value = '0;
      mstatus_value[MSTATUS_MIE_BIT]  = mstatus_mie_reg;
      mstatus_value[MSTATUS_MPIE_BIT] = mstatus_mpie_reg;
   end

   always_comb begin
      csr_rdata   = '0;
      implemented = 1'b1;
      read_only   = 1'b0;
      case (csr_addr)
         CSR_MSTATUS:  csr_rdata = mstatus_value;
         CSR_MIE:      csr_rdata = mie_reg;
         CSR_MTVEC:    csr_rdata = mtvec_reg;
         CSR_MSCRATCH: csr_rdata = mscratch_reg;
         CSR_MEPC:     csr_rdata = mepc_reg;
         CSR_MCAUSE:   csr_rdata = mcause_reg;
         CSR_MTVAL:    csr_rdata = mtval_reg;
         CSR_MIP: begin
            csr_rdata = mip_value;
            read_only = 1'b1;
         end
         CSR_MCYCLE:   csr_rdata = XLEN'(cnt_value[0]);
         CSR_MINSTRET: csr_rdata = XLEN'(cnt_value[1]);
         CSR_MCYCLEH: begin
            if (XLEN == 32) csr_rdata = XLEN'(cnt_value[0][63:32]);
            else            implemented = 1'b0;
         end
         CSR_MINSTRETH: begin
            if (XLEN == 32) csr_rdata = XLEN'(cnt_value[1][63:32]);
            else            implemented = 1'b0;
         end
         default:      implemented = 1'b0;
      endcase
   end

   assign csr_illegal = (csr_op != CSR_NONE) && (!implemented || read_only);

   always_comb begin
      case (csr_op_e'(csr_op))
         CSR_WRITE: wval = csr_wdata;
         CSR_SET:   wval = csr_rdata | csr_wdata;
         CSR_CLEAR: wval = csr_rdata & ~csr_wdata;
         default:   wval = csr_rdata;
      endcase
      wval64 = 64'(wval);
      mtvec_wval = wval;
      mtvec_wval[1] = 1'b0;
      if (!VECTORED_EN) mtvec_wval[0] = 1'b0;
      mtvec_rst = MTVEC_RESET;
      mtvec_rst[1] = 1'b0;
      if (!VECTORED_EN) mtvec_rst[0] = 1'b0;
   end

   // Lowest-numbered enabled pending line wins.
   always_comb begin
      irq_hit = 1'b0;
      irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (mip_value[16+i] && mie_reg[16+i]) begin
            irq_hit = 1'b1;
            irq_idx = 5'(i);
         end
      end
   end

   always_comb begin
      int_pending = mstatus_mie_reg && irq_hit;
      irq_cause   = CAUSE_IRQ_BASE + irq_idx;
      mtvec_base  = {mtvec_reg[XLEN-1:2], 2'b00};
      exc_mcause  = XLEN'(exc_cause);
      int_mcause  = XLEN'(irq_cause);
      int_mcause[XLEN-1] = 1'b1;
      int_target  = mtvec_reg[0] ? (mtvec_base + XLEN'({irq_cause, 2'b00})) : mtvec_base;
   end

   // CSR writes are the lowest-priority event and vanish under any trap or MRET.
   assign csr_we = (csr_op != CSR_NONE) && !csr_illegal && !exc_valid && !int_pending && !mret;

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_reg    <= 1'b0;
         mstatus_mpie_reg   <= 1'b0;
         mie_reg            <= '0;
         mtvec_reg          <= mtvec_rst;
         mscratch_reg       <= '0;
         mepc_reg           <= '0;
         mcause_reg         <= '0;
         mtval_reg          <= '0;
         irq_sync_reg       <= '0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
      end else begin
         irq_sync_reg       <= irq;
         redirect_valid_reg <= 1'b0;
         if (exc_valid || int_pending) begin
            mepc_reg           <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_reg         <= exc_valid ? exc_mcause : int_mcause;
            mtval_reg          <= exc_valid ? exc_tval : '0;
            mstatus_mpie_reg   <= mstatus_mie_reg;
            mstatus_mie_reg    <= 1'b0;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= exc_valid ? mtvec_base : int_target;
         end else if (mret) begin
            mstatus_mie_reg    <= mstatus_mpie_reg;
            mstatus_mpie_reg   <= 1'b1;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= mepc_reg;
         end else if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie_reg  <= wval[MSTATUS_MIE_BIT];
                  mstatus_mpie_reg <= wval[MSTATUS_MPIE_BIT];
               end
               CSR_MIE:      mie_reg      <= wval;
               CSR_MTVEC:    mtvec_reg    <= mtvec_wval;
               CSR_MSCRATCH: mscratch_reg <= wval;
               CSR_MEPC:     mepc_reg     <= {wval[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause_reg   <= wval;
               CSR_MTVAL:    mtval_reg    <= wval;
               default: ;
            endcase
         end
      end
   end

   assign cnt_inc = {instret, 1'b1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         localparam logic [11:0] LO_ADDR = (gi == 0) ? CSR_MCYCLE  : CSR_MINSTRET;
         localparam logic [11:0] HI_ADDR = (gi == 0) ? CSR_MCYCLEH : CSR_MINSTRETH;
         logic [31:0] hi_wdata;

         assign lo_we[gi] = csr_we && (csr_addr == LO_ADDR);
         assign hi_we[gi] = csr_we && (csr_addr == ((XLEN == 32) ? HI_ADDR : LO_ADDR));
         assign hi_wdata  = (XLEN == 32) ? wval64[31:0] : wval64[63:32];

         rip_csr_counter u_counter (
            .clk      (clk),
            .rst      (rst),
            .inc      (cnt_inc[gi]),
            .lo_we    (lo_we[gi]),
            .lo_wdata (wval64[31:0]),
            .hi_we    (hi_we[gi]),
            .hi_wdata (hi_wdata),
            .count    (cnt_value[gi])
         );
      end
   endgenerate

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_rip_csr_file.sv
// Directed bench for rip_csr_file with a redirect scoreboard and CSR read-back checks.
module tb_rip_csr_file;

   localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
   localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344, A_MCYCLE = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] csr_addr = '0;
   logic [1:0]  csr_op = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_cause = '0;
   logic [31:0] exc_tval = '0;
   logic [31:0] trap_pc = '0;
   logic        mret = 1'b0;
   logic        instret = 1'b0;
   logic [3:0]  irq = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   rip_csr_file dut (
      .clk            (clk),
      .rst            (rst),
      .csr_addr       (csr_addr),
      .csr_op         (csr_op),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .csr_illegal    (csr_illegal),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_tval       (exc_tval),
      .trap_pc        (trap_pc),
      .mret           (mret),
      .instret        (instret),
      .irq            (irq),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; compares the redirect output against the scoreboard head.
   task automatic tick();
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         chk("redirect_valid", 32'(redirect_valid), 32'd1);
         chk("redirect_pc", redirect_pc, e);
         $display("redirect observed pc=%h expected %h", redirect_pc, e);
      end else begin
         chk("no_redirect", 32'(redirect_valid), 32'd0);
      end
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
      csr_addr = addr;
      csr_op   = 2'd0;
      #1;
      chk(tag, csr_rdata, exp);
      $display("read  addr=%h data=%h", addr, csr_rdata);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
      csr_addr  = addr;
      csr_op    = op;
      csr_wdata = data;
      $display("write addr=%h op=%0d data=%h", addr, op, data);
      tick();
      csr_op    = 2'd0;
   endtask

   initial begin
      // Reset
      tick();
      tick();
      rst = 1'b0;
      chk("reset_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      rd(A_MTVEC, 32'h0, "reset_mtvec");
      rd(A_MSTATUS, 32'h0, "reset_mstatus");
      rd(A_MCAUSE, 32'h0, "reset_mcause");
      rd(A_MINSTRET, 32'h0, "reset_minstret");

      // Exception to direct mtvec
      wr(A_MTVEC, 2'd1, 32'h100);
      rd(A_MTVEC, 32'h100, "mtvec_write");
      exc_valid = 1'b1; exc_cause = 5'd2; trap_pc = 32'h40; exc_tval = 32'h1234;
      exp_q.push_back(32'h100);
      $display("exception cause=2 pc=40");
      tick();
      exc_valid = 1'b0;
      rd(A_MEPC, 32'h40, "exc_mepc");
      rd(A_MCAUSE, 32'h2, "exc_mcause");
      rd(A_MTVAL, 32'h1234, "exc_mtval");
      rd(A_MSTATUS, 32'h0, "exc_mstatus");

      // Vectored interrupt on line 1
      wr(A_MTVEC, 2'd1, 32'h103);
      rd(A_MTVEC, 32'h101, "mtvec_bit1_hardwired");
      wr(A_MIE, 2'd2, 32'h0002_0000);
      wr(A_MSTATUS, 2'd2, 32'h8);
      rd(A_MSTATUS, 32'h8, "mstatus_mie_set");
      irq = 4'b0010; trap_pc = 32'h88;
      tick();
      rd(A_MIP, 32'h0002_0000, "mip_sync");
      exp_q.push_back(32'h144);
      $display("interrupt line 1 expected");
      tick();
      irq = 4'b0000;
      rd(A_MCAUSE, 32'h8000_0011, "int_mcause");
      rd(A_MTVAL, 32'h0, "int_mtval");
      rd(A_MEPC, 32'h88, "int_mepc");
      rd(A_MSTATUS, 32'h80, "int_mstatus");

      // MRET
      wr(A_MEPC, 2'd1, 32'h203);
      rd(A_MEPC, 32'h200, "mepc_low_bits");
      mret = 1'b1;
      exp_q.push_back(32'h200);
      $display("mret to 200");
      tick();
      mret = 1'b0;
      rd(A_MSTATUS, 32'h88, "mret_mstatus");

      // Exception, interrupt, mret and CSR write in one cycle
      irq = 4'b0010;
      tick();
      exc_valid = 1'b1; exc_cause = 5'd3; trap_pc = 32'h300; exc_tval = 32'h0;
      mret = 1'b1;
      csr_addr = A_MSCRATCH; csr_op = 2'd1; csr_wdata = 32'hDEAD;
      exp_q.push_back(32'h100);
      $display("exception+irq+mret+write same cycle");
      tick();
      exc_valid = 1'b0; mret = 1'b0; csr_op = 2'd0; irq = 4'b0000;
      tick();
      rd(A_MCAUSE, 32'h3, "prio_mcause");
      rd(A_MEPC, 32'h300, "prio_mepc");
      rd(A_MSTATUS, 32'h80, "prio_mstatus");
      rd(A_MSCRATCH, 32'h0, "prio_write_dropped");

      // Illegal accesses
      csr_addr = A_MIP; csr_op = 2'd1; csr_wdata = 32'hFFFF_FFFF;
      #1 chk("illegal_mip", 32'(csr_illegal), 32'd1);
      tick();
      csr_addr = 12'h7FF; csr_op = 2'd1; csr_wdata = 32'h55;
      #1 chk("illegal_7ff", 32'(csr_illegal), 32'd1);
      tick();
      csr_addr = A_MSCRATCH; csr_op = 2'd1;
      #1 chk("legal_mscratch", 32'(csr_illegal), 32'd0);
      csr_op = 2'd0;
      rd(A_MIP, 32'h0, "mip_unchanged");
      rd(A_MSCRATCH, 32'h0, "mscratch_unchanged");
      wr(A_MSCRATCH, 2'd2, 32'h5555);
      wr(A_MSCRATCH, 2'd3, 32'h0005);
      rd(A_MSCRATCH, 32'h5550, "set_clear");

      // Counters: wrap and write override
      wr(A_MCYCLE, 2'd1, 32'hFFFF_FFFF);
      wr(A_MCYCLEH, 2'd1, 32'hFFFF_FFFF);
      rd(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_all_ones");
      tick();
      rd(A_MCYCLE, 32'h0, "mcycle_wrap_lo");
      rd(A_MCYCLEH, 32'h0, "mcycle_wrap_hi");
      instret = 1'b1;
      tick(); tick(); tick();
      instret = 1'b0;
      rd(A_MINSTRET, 32'h3, "minstret_count");
      instret = 1'b1;
      wr(A_MINSTRET, 2'd1, 32'h10);
      instret = 1'b0;
      rd(A_MINSTRET, 32'h10, "minstret_write_override");

      // Reset during trap
      exc_valid = 1'b1; exc_cause = 5'd2; trap_pc = 32'h500; rst = 1'b1;
      $display("reset during exception");
      tick();
      exc_valid = 1'b0; rst = 1'b0;
      tick();
      rd(A_MEPC, 32'h0, "rst_mepc");
      rd(A_MTVEC, 32'h0, "rst_mtvec");
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
